// File: rtl/calc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator operand-entry sequencer:
//   - CALC_W     : default operand/result width
//   - state_t    : sequencer FSM states and their fixed encodings
//   - OP_*       : calculator opcodes as seen on calc_op
// ---------------------------------------------------------------------------
package calc_pkg;

  localparam int CALC_W = 4;

  // Encodings are visible on the state output, so they are pinned explicitly.
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  // Opcodes understood by the combinational calculator. For the two abs
  // opcodes the calculator ignores bit 0, so 3'b011 and 3'b111 behave the
  // same as the values listed here.
  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;

  // True for either abs opcode, whatever the value of the don't-care bit.
  function automatic logic op_is_abs(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// ---------------------------------------------------------------------------
// calc_sequencer_if
// Bus between the sequencer and the combinational calculator.
//   calc_a, calc_b : registered operands (sequencer -> calculator)
//   calc_op        : registered opcode   (sequencer -> calculator)
//   calc_r         : calculator result   (calculator -> sequencer)
//   calc_ovf       : calculator overflow (calculator -> sequencer)
// Modports:
//   master : the sequencer side
//   slave  : the calculator side
// ---------------------------------------------------------------------------
interface calc_sequencer_if #(
  parameter int W = calc_pkg::CALC_W
);

  logic [W-1:0] calc_a;
  logic [W-1:0] calc_b;
  logic [2:0]   calc_op;
  logic [W-1:0] calc_r;
  logic         calc_ovf;

  modport master (
    output calc_a,
    output calc_b,
    output calc_op,
    input  calc_r,
    input  calc_ovf
  );

  modport slave (
    input  calc_a,
    input  calc_b,
    input  calc_op,
    output calc_r,
    output calc_ovf
  );

endinterface

// File: rtl/calc_sequencer_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect
// Rising-edge detector for the (already synchronised) ENTER level.
// Ports:
//   clk   in  : system clock, rising edge
//   rst   in  : asynchronous active-high reset
//   clr   in  : synchronous clear, same effect as reset
//   enter in  : ENTER level
//   pulse out : high for one cycle when enter rises
// ---------------------------------------------------------------------------
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic enter,
  output logic pulse
);

  logic enter_q;

  // The history bit starts at 1 so a button held through reset or clear
  // must first be seen low before it can produce a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enter_q <= 1'b1;
    end else if (clr) begin
      enter_q <= 1'b1;
    end else begin
      enter_q <= enter;
    end
  end

  assign pulse = enter & ~enter_q;

endmodule

// File: rtl/calc_sequencer.sv
// ---------------------------------------------------------------------------
// calc_sequencer
// Collects A, B and OP from the switches over successive ENTER presses,
// presents them from registers to an external combinational calculator,
// captures its result one cycle later and holds it for display.
// Ports:
//   clk          in  : system clock, rising edge
//   rst          in  : asynchronous active-high reset
//   enter        in  : ENTER level, synchronised to clk
//   clr          in  : synchronous clear (acts like reset on the next edge)
//   sw           in  : switch value (operand, or opcode in bits [2:0])
//   calc         --  : calculator bus (master side): calc_a/calc_b/calc_op
//                      out, calc_r/calc_ovf in
//   result       out : captured result
//   ovf          out : captured overflow
//   result_valid out : high while showing a result
//   done         out : one-cycle pulse on the cycle the result appears
//   state        out : current FSM state encoding
//   disp         out : sw while entering, captured result while showing
// Build option:
//   CALC_CHAIN_EN : when defined, a press while showing feeds the result
//                   back as operand A and continues at operand B entry.
// ---------------------------------------------------------------------------
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W = CALC_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enter,
  input  logic                 clr,
  input  logic [W-1:0]         sw,
  calc_sequencer_if.master     calc,
  output logic [W-1:0]         result,
  output logic                 ovf,
  output logic                 result_valid,
  output logic                 done,
  output logic [2:0]           state,
  output logic [W-1:0]         disp
);

  state_t       state_q;
  state_t       state_d;
  logic         pulse;
  logic [W-1:0] a_reg;
  logic [W-1:0] b_reg;
  logic [2:0]   op_reg;
  logic [W-1:0] r_reg;
  logic         ovf_reg;
  logic         done_reg;

  logic         load_a;
  logic         load_b;
  logic         load_op;
  logic         capture;
  logic         chain;

  edge_detect u_edge_detect (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .enter (enter),
    .pulse (pulse)
  );

  // Next-state and register-load decisions. S_EXEC always lasts exactly one
  // cycle and ignores presses, so the calculator sees stable operands for
  // the whole cycle before its output is captured.
  always_comb begin
    state_d = state_q;
    load_a  = 1'b0;
    load_b  = 1'b0;
    load_op = 1'b0;
    capture = 1'b0;
    chain   = 1'b0;
    case (state_q)
      S_A: begin
        if (pulse) begin
          load_a  = 1'b1;
          state_d = S_B;
        end
      end
      S_B: begin
        if (pulse) begin
          load_b  = 1'b1;
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (pulse) begin
          load_op = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        capture = 1'b1;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (pulse) begin
`ifdef CALC_CHAIN_EN
          chain   = 1'b1;
          state_d = S_B;
`else
          state_d = S_A;
`endif
        end
      end
      default: begin
        state_d = S_A;
      end
    endcase
  end

  // State register; clear wins over any press seen in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
    end else if (clr) begin
      state_q <= S_A;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, opcode and result registers. Operands are kept after a result
  // is shown so the user can see what was entered; the result holds until
  // the next capture. When chaining, the previous result becomes A and the
  // stale overflow flag is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      r_reg    <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else if (clr) begin
      a_reg    <= '0;
      b_reg    <= '0;
      op_reg   <= '0;
      r_reg    <= '0;
      ovf_reg  <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      if (load_a) begin
        a_reg <= sw;
      end
      if (chain) begin
        a_reg   <= r_reg;
        ovf_reg <= 1'b0;
      end
      if (load_b) begin
        b_reg <= sw;
      end
      if (load_op) begin
        op_reg <= sw[2:0];
      end
      if (capture) begin
        r_reg   <= calc.calc_r;
        ovf_reg <= calc.calc_ovf;
      end
      done_reg <= capture;
    end
  end

  assign calc.calc_a  = a_reg;
  assign calc.calc_b  = b_reg;
  assign calc.calc_op = op_reg;

  assign result       = r_reg;
  assign ovf          = ovf_reg;
  assign done         = done_reg;
  assign state        = state_q;
  assign result_valid = (state_q == S_SHOW);
  assign disp         = (state_q == S_SHOW) ? r_reg : sw;

endmodule

// File: tb/tb_calc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_calc_sequencer
// Directed bench for calc_sequencer with a behavioural 4-bit calculator
// attached on the slave side of the calculator bus. Expected values are
// hand-computed constants. Define CALC_CHAIN_EN to exercise chaining.
// ---------------------------------------------------------------------------
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int W = CALC_W;

  logic         clk;
  logic         rst;
  logic         enter;
  logic         clr;
  logic [W-1:0] sw;
  logic [W-1:0] result;
  logic         ovf;
  logic         result_valid;
  logic         done;
  logic [2:0]   state;
  logic [W-1:0] disp;

  int vectors_applied;
  int miscompares;

  calc_sequencer_if #(.W(W)) bus ();

  calc_sequencer #(.W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enter        (enter),
    .clr          (clr),
    .sw           (sw),
    .calc         (bus),
    .result       (result),
    .ovf          (ovf),
    .result_valid (result_valid),
    .done         (done),
    .state        (state),
    .disp         (disp)
  );

  // Reference calculator: bit 2 swaps the operand order, bit 1 selects abs
  // of the second operand, bit 0 selects subtract.
  logic [W-1:0] xa;
  logic [W-1:0] xb;
  logic [W-1:0] rv;
  logic         ov;
  always_comb begin
    xa = bus.calc_op[2] ? bus.calc_b : bus.calc_a;
    xb = bus.calc_op[2] ? bus.calc_a : bus.calc_b;
    rv = '0;
    ov = 1'b0;
    if (bus.calc_op[1]) begin
      rv = xb[W-1] ? (~xb + 1'b1) : xb;
      ov = (xb == {1'b1, {(W-1){1'b0}}});
    end else if (bus.calc_op[0]) begin
      rv = xa - xb;
      ov = (xa[W-1] != xb[W-1]) && (rv[W-1] != xa[W-1]);
    end else begin
      rv = xa + xb;
      ov = (xa[W-1] == xb[W-1]) && (rv[W-1] != xa[W-1]);
    end
  end
  assign bus.calc_r   = rv;
  assign bus.calc_ovf = ov;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then land 1 ns after the next rising edge.
  task automatic applyStimulus(input logic e, input logic c,
                               input logic [W-1:0] s);
    enter = e;
    clr   = c;
    sw    = s;
    @(posedge clk);
    #1;
  endtask

  task automatic enterValue(input logic [W-1:0] s);
    applyStimulus(1'b1, 1'b0, s);
    applyStimulus(1'b0, 1'b0, s);
  endtask

  // Ends on the first S_SHOW cycle (done high).
  task automatic runCalc(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] op);
    enterValue(a);
    enterValue(b);
    enterValue({{(W-3){1'b0}}, op});
  endtask

  task automatic clearAll();
    applyStimulus(1'b0, 1'b1, '0);
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst   = 1'b1;
    enter = 1'b0;
    clr   = 1'b0;
    sw    = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state", state, 0);
    checkOutput("rst_valid", result_valid, 0);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd9);
    checkOutput("idle_state", state, 0);
    checkOutput("idle_result", result, 0);
    checkOutput("idle_ovf", ovf, 0);
    checkOutput("idle_done", done, 0);
    checkOutput("idle_disp", disp, 9);

    // 3 + 2 with latency checks
    enterValue(4'd3);
    checkOutput("t1_state_b", state, 1);
    checkOutput("t1_a", bus.calc_a, 3);
    enterValue(4'd2);
    checkOutput("t1_b", bus.calc_b, 2);
    applyStimulus(1'b1, 1'b0, {1'b0, OP_ADD_AB});
    checkOutput("t1_exec", state, 3);
    checkOutput("t1_exec_valid", result_valid, 0);
    checkOutput("t1_exec_done", done, 0);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t1_show", state, 4);
    checkOutput("t1_result", result, 4'b0101);
    checkOutput("t1_ovf", ovf, 0);
    checkOutput("t1_valid", result_valid, 1);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_disp", disp, 5);
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("t1_done_off", done, 0);
    checkOutput("t1_hold", state, 4);

    // 7 + 1 overflows, then a press leaves S_SHOW
    clearAll();
    runCalc(4'd7, 4'd1, OP_ADD_AB);
    checkOutput("t2_result", result, 4'b1000);
    checkOutput("t2_ovf", ovf, 1);
    enterValue(4'd0);
`ifdef CALC_CHAIN_EN
    checkOutput("t2_chain_state", state, 1);
    checkOutput("t2_chain_a", bus.calc_a, 8);
    checkOutput("t2_chain_ovf", ovf, 0);
`else
    checkOutput("t2_next_state", state, 0);
    checkOutput("t2_keep_ovf", ovf, 1);
    checkOutput("t2_keep_a", bus.calc_a, 7);
`endif
    checkOutput("t2_keep_result", result, 4'b1000);

    // abs A of -3
    clearAll();
    runCalc(4'b1101, 4'd0, OP_ABS_A);
    checkOutput("t3_result", result, 4'b0011);
    checkOutput("t3_ovf", ovf, 0);

    // enter held high: exactly one press
    clearAll();
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 4'd5);
    checkOutput("hold_state", state, 1);
    checkOutput("hold_a", bus.calc_a, 5);
    applyStimulus(1'b0, 1'b0, 4'd6);
    checkOutput("hold_after", state, 1);
    checkOutput("hold_disp", disp, 6);

    // enter high across reset release
    enter = 1'b1;
    rst   = 1'b1;
    applyStimulus(1'b1, 1'b0, 4'd5);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 4'd5);
    checkOutput("rst_hold_state", state, 0);
    applyStimulus(1'b0, 1'b0, 4'd5);
    applyStimulus(1'b1, 1'b0, 4'd5);
    checkOutput("rst_hold_press", state, 1);
    applyStimulus(1'b0, 1'b0, 4'd5);

    // clr beats a simultaneous press in S_OP
    clearAll();
    enterValue(4'd3);
    enterValue(4'd2);
    checkOutput("clr_pre", state, 2);
    applyStimulus(1'b1, 1'b1, 4'd1);
    checkOutput("clr_state", state, 0);
    checkOutput("clr_a", bus.calc_a, 0);
    checkOutput("clr_b", bus.calc_b, 0);
    checkOutput("clr_op", bus.calc_op, 0);
    applyStimulus(1'b0, 1'b0, 4'd0);

    // async reset while in S_EXEC
    enterValue(4'd6);
    enterValue(4'd1);
    applyStimulus(1'b1, 1'b0, {1'b0, OP_ADD_AB});
    checkOutput("rexec_pre", state, 3);
    rst = 1'b1;
    #2;
    checkOutput("rexec_state", state, 0);
    checkOutput("rexec_valid", result_valid, 0);
    checkOutput("rexec_a", bus.calc_a, 0);
    enter = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0);
    checkOutput("rexec_after", state, 0);
    checkOutput("rexec_done", done, 0);
    checkOutput("rexec_result", result, 0);

`ifdef CALC_CHAIN_EN
    // chaining: (3 + 2) - 1
    clearAll();
    runCalc(4'd3, 4'd2, OP_ADD_AB);
    checkOutput("ch_first", result, 5);
    enterValue(4'd9);
    checkOutput("ch_state_b", state, 1);
    checkOutput("ch_a", bus.calc_a, 5);
    enterValue(4'd1);
    enterValue({1'b0, OP_SUB_AB});
    checkOutput("ch_result", result, 4);
    checkOutput("ch_state", state, 4);
    enterValue(4'd0);
    checkOutput("ch_again", state, 1);
    applyStimulus(1'b0, 1'b1, 4'd0);
    checkOutput("ch_clr", state, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied,
             miscompares);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
Name: calc_sequencer

Overview:
Sequential operand-entry and result-capture stage that wraps the team's 4-bit combinational calculator. It collects A, B and OP from switch inputs over successive ENTER presses. It drives the registered operands into the calculator, captures its R/ovf one cycle later, and holds the result for display. It is the upstream feeder and the downstream consumer of the combinational calculator.

Parameters:
- W, 4: operand/result width in bits (two's complement). W >= 3 because OP is taken from sw[2:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- enter  in  1  ENTER button level, already synchronised to clk.
- clr  in  1  synchronous clear, active-high.
- sw  in  W  switch value: operand, or opcode in bits [2:0].
- calc_a  out  W  operand A to calculator (= a_reg).
- calc_b  out  W  operand B to calculator (= b_reg).
- calc_op  out  3  opcode to calculator (= op_reg).
- calc_r  in  W  calculator result (combinational).
- calc_ovf  in  1  calculator overflow (combinational).
- result  out  W  captured result (r_reg).
- ovf  out  1  captured overflow.
- result_valid  out  1  high while in S_SHOW.
- done  out  1  one-cycle pulse when the result is captured.
- state  out  3  current FSM state encoding.
- disp  out  W  display value: sw in S_A/S_B/S_OP/S_EXEC, r_reg in S_SHOW.

Behaviour:
- Reset (rst=1, async): state=S_A; a_reg, b_reg, op_reg, r_reg = 0; ovf=0; done=0; result_valid=0; enter_q=1.
- Edge detect: pulse = enter & ~enter_q; enter_q <= enter every cycle.
  - Holding enter through and after reset yields no pulse until enter has been seen low.
  - Holding enter high yields exactly one pulse.
- FSM encodings: S_A=0, S_B=1, S_OP=2, S_EXEC=3, S_SHOW=4.
  - S_A, on pulse: a_reg <= sw; go to S_B.
  - S_B, on pulse: b_reg <= sw; go to S_OP.
  - S_OP, on pulse: op_reg <= sw[2:0]; go to S_EXEC.
  - S_EXEC: unconditional single cycle. r_reg <= calc_r; ovf <= calc_ovf; done=1 (registered, asserted during the S_SHOW entry cycle); go to S_SHOW. Any pulse here is ignored.
  - S_SHOW: result_valid=1. On pulse, go to S_A; a_reg/b_reg/op_reg are retained and r_reg/ovf hold until the next capture.
- Latency: pulse in S_OP at cycle t → S_EXEC at t+1 → result/ovf/result_valid/done valid at t+2.
- Without a pulse the FSM holds its state indefinitely.
- clr=1 in any state: same effect as reset on the next edge. clr takes priority over a simultaneous pulse.
- rst asserted mid-sequence: immediate return to the reset state; partial entries are discarded.
- calc_a/calc_b/calc_op come straight from registers (no combinational path from sw). The calculator output is therefore stable throughout S_EXEC.
- Arithmetic is performed entirely by the calculator. This block never modifies r_reg, and the width is always W.

Optional Feature:
- Macro: CALC_CHAIN_EN.
- Defined: a pulse in S_SHOW loads a_reg <= r_reg and goes to S_B (accumulator chaining); ovf is cleared on that transition. clr still returns to S_A.
- Undefined: a pulse in S_SHOW goes to S_A as specified above.

Decomposition:
- Package calc_pkg:
  - state type/encodings S_A..S_SHOW.
  - opcode constants OP_ADD_AB=3'b000, OP_SUB_AB=3'b001, OP_ABS_B=3'b01x, OP_ADD_BA=3'b100, OP_SUB_BA=3'b101, OP_ABS_A=3'b11x.
  - default width constant CALC_W=4.
- Sub-module: edge_detect (enter_q register with reset value 1, pulse output).
- The FSM and datapath stay in calc_sequencer. The calculator is instantiated by the bench/top, not inside this block.

Test Plan:
- sw=3,2,000 entered on three pulses, with the calculator model attached → at t+2: result=4'b0101, ovf=0, result_valid=1, done pulsed for exactly 1 cycle.
- sw=7,1,000 → result=4'b1000, ovf=1; then a pulse → state=S_A, result still 4'b1000.
- sw=4'b1101, 0, 3'b110 (abs A) → result=4'b0011, ovf=0.
- enter held high for 10 cycles in S_A with sw=5 → a_reg=5, state=S_B, no further advance; enter high across reset release → state stays S_A until enter goes low then high.
- clr asserted together with a pulse in S_OP → state=S_A and all registers 0 next cycle; rst pulsed in S_EXEC → result_valid=0 immediately.
- CALC_CHAIN_EN defined: 3+2 → 5, then pulse, sw=1, pulse, sw=001, pulse → result=4 and state goes S_SHOW→S_B.
